// File: rtl/riscv_pkg.sv
// Shared RISC-V decode constants and write-back source selection.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned FUNCT3_W = 3;

    localparam logic [OPCODE_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRA   = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_ALUI  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_ALU   = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_AUIPC = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OP_JALR  = 7'b1100111;

    localparam logic [FUNCT3_W-1:0] FCT3_LB  = 3'b000;
    localparam logic [FUNCT3_W-1:0] FCT3_LH  = 3'b001;
    localparam logic [FUNCT3_W-1:0] FCT3_LW  = 3'b010;
    localparam logic [FUNCT3_W-1:0] FCT3_LD  = 3'b011;
    localparam logic [FUNCT3_W-1:0] FCT3_LBU = 3'b100;
    localparam logic [FUNCT3_W-1:0] FCT3_LHU = 3'b101;
    localparam logic [FUNCT3_W-1:0] FCT3_LWU = 3'b110;

    typedef enum logic [2:0] {
        WB_MEM,
        WB_ALU,
        WB_PCIMM,
        WB_IMM,
        WB_PC4,
        WB_ZERO
    } wb_sel_t;

    // Map an opcode to its write-back source; WB_ZERO marks non-writing opcodes.
    function automatic wb_sel_t wb_sel_of(input logic [OPCODE_W-1:0] opcode);
        wb_sel_t sel;
        case (opcode)
            OP_LOAD:         sel = WB_MEM;
            OP_ALUI, OP_ALU: sel = WB_ALU;
            OP_AUIPC:        sel = WB_PCIMM;
            OP_LUI:          sel = WB_IMM;
            OP_JAL, OP_JALR: sel = WB_PC4;
            default:         sel = WB_ZERO;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/load_align.sv
// Extracts and extends the addressed load value from a naturally aligned memory word.
module load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned OFS_W = 2
) (
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [OFS_W-1:0]    offset,
    input  logic [XLEN-1:0]     raw,
    output logic [XLEN-1:0]     data,
    output logic                misaligned,
    output logic                legal
);

    logic [XLEN-1:0] shifted;

    // Shift the addressed byte down to bit 0, then size/extend by funct3.
    always_comb begin
        shifted    = raw >> {offset, 3'b000};
        data       = '0;
        misaligned = 1'b0;
        legal      = 1'b1;
        case (funct3)
            FCT3_LB:  data = XLEN'($signed(shifted[7:0]));
            FCT3_LBU: data = XLEN'(shifted[7:0]);
            FCT3_LH: begin
                data       = XLEN'($signed(shifted[15:0]));
                misaligned = offset[0];
            end
            FCT3_LHU: begin
                data       = XLEN'(shifted[15:0]);
                misaligned = offset[0];
            end
            FCT3_LW: begin
                data       = XLEN'($signed(shifted[31:0]));
                misaligned = (offset[1:0] != 2'b00);
            end
            FCT3_LWU: begin
                if (XLEN == 64) begin
                    data       = XLEN'(shifted[31:0]);
                    misaligned = (offset[1:0] != 2'b00);
                end else begin
                    legal = 1'b0;
                end
            end
            FCT3_LD: begin
                if (XLEN == 64) begin
                    data       = shifted;
                    misaligned = (offset != '0);
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        if (misaligned) begin
            data = '0;
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Registered write-back stage: captures MEM results, selects the destination value,
// drives the register-file write port and its forwarding copy, counts retirements.
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned RET_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               stop,
    input  logic               jump,
    input  logic [31:0]        inst_M,
    input  logic [XLEN-1:0]    pc_M,
    input  logic [XLEN-1:0]    alu_res_M,
    input  logic [XLEN-1:0]    mem_rdata_M,
    input  logic [XLEN-1:0]    imm_M,
    output logic               wb_we,
    output logic [RADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data,
    output logic               misalign,
    output logic [RET_W-1:0]   retired
);

    localparam int unsigned OFS_W = $clog2(XLEN / 8);

    logic                valid;
    logic                fresh;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [RADDR_W-1:0]  rd;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     alu_res;
    logic [XLEN-1:0]     mem_rdata;
    logic [XLEN-1:0]     imm;

    logic [XLEN-1:0]     ld_data;
    logic                ld_mis;
    logic                ld_legal;
    wb_sel_t             sel;
    logic                live;
    logic                is_load;

    // Immediate/rs fields of the instruction word are not needed past decode.
    logic unused_inst;
    assign unused_inst = ^inst_M[31:15];

    // Stage register: flush beats stall beats capture; stall retires freshness.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid     <= 1'b0;
            fresh     <= 1'b0;
            opcode    <= '0;
            funct3    <= '0;
            rd        <= '0;
            pc        <= '0;
            alu_res   <= '0;
            mem_rdata <= '0;
            imm       <= '0;
        end else if (jump) begin
            valid <= 1'b0;
            fresh <= 1'b0;
        end else if (stop) begin
            fresh <= 1'b0;
        end else if (in_valid) begin
            valid     <= 1'b1;
            fresh     <= 1'b1;
            opcode    <= inst_M[6:0];
            funct3    <= inst_M[14:12];
            rd        <= RADDR_W'(inst_M[11:7]);
            pc        <= pc_M;
            alu_res   <= alu_res_M;
            mem_rdata <= mem_rdata_M;
            imm       <= imm_M;
        end else begin
            valid <= 1'b0;
            fresh <= 1'b0;
        end
    end

    load_align #(
        .XLEN  (XLEN),
        .OFS_W (OFS_W)
    ) u_load_align (
        .funct3     (funct3),
        .offset     (alu_res[OFS_W-1:0]),
        .raw        (mem_rdata),
        .data       (ld_data),
        .misaligned (ld_mis),
        .legal      (ld_legal)
    );

    // Result mux and write qualification, driven only from the stage register.
    always_comb begin
        sel      = wb_sel_of(opcode);
        live     = valid & fresh;
        is_load  = (opcode == OP_LOAD);
        misalign = live & is_load & ld_mis;
        wb_we    = live & (sel != WB_ZERO) & (rd != '0) & ~misalign & (~is_load | ld_legal);
        wb_data  = '0;
        if (valid) begin
            case (sel)
                WB_MEM:   wb_data = ld_data;
                WB_ALU:   wb_data = alu_res;
                WB_PCIMM: wb_data = pc + imm;
                WB_IMM:   wb_data = imm;
                WB_PC4:   wb_data = pc + XLEN'(4);
                default:  wb_data = '0;
            endcase
        end
    end

    assign wb_rd     = rd;
    assign fwd_valid = wb_we;
    assign fwd_rd    = rd;
    assign fwd_data  = wb_data;

    // Retired-instruction counter, wraps naturally at 2^RET_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired <= '0;
        end else if (valid & fresh & ~misalign) begin
            retired <= retired + RET_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage (XLEN=32, RET_W=4) against a behavioural model.
module tb_writeback_stage;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned RET_W   = 4;

    localparam logic [6:0] LOAD  = 7'h03;
    localparam logic [6:0] STORE = 7'h23;
    localparam logic [6:0] BRA   = 7'h63;
    localparam logic [6:0] ALUI  = 7'h13;
    localparam logic [6:0] ALU   = 7'h33;
    localparam logic [6:0] AUIPC = 7'h17;
    localparam logic [6:0] LUI   = 7'h37;
    localparam logic [6:0] JAL   = 7'h6F;
    localparam logic [6:0] JALR  = 7'h67;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               stop = 1'b0;
    logic               jump = 1'b0;
    logic [31:0]        inst_M = '0;
    logic [XLEN-1:0]    pc_M = '0;
    logic [XLEN-1:0]    alu_res_M = '0;
    logic [XLEN-1:0]    mem_rdata_M = '0;
    logic [XLEN-1:0]    imm_M = '0;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               fwd_valid;
    logic [RADDR_W-1:0] fwd_rd;
    logic [XLEN-1:0]    fwd_data;
    logic               misalign;
    logic [RET_W-1:0]   retired;

    int n_vec = 0;
    int n_err = 0;

    // Model of the stage: the instruction currently held and the retire count.
    logic        m_valid = 1'b0;
    logic        m_fresh = 1'b0;
    logic [31:0] m_inst  = '0;
    logic [31:0] m_pc    = '0;
    logic [31:0] m_alu   = '0;
    logic [31:0] m_rdata = '0;
    logic [31:0] m_imm   = '0;
    int unsigned m_ret   = 0;

    always #5 clk = ~clk;

    writeback_stage #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W),
        .RET_W   (RET_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .stop        (stop),
        .jump        (jump),
        .inst_M      (inst_M),
        .pc_M        (pc_M),
        .alu_res_M   (alu_res_M),
        .mem_rdata_M (mem_rdata_M),
        .imm_M       (imm_M),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .fwd_valid   (fwd_valid),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .misalign    (misalign),
        .retired     (retired)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        return {17'h0, f3, rd, op};
    endfunction

    // Load value from the memory word, by plain byte arithmetic.
    function automatic void model_load(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] raw, output logic [31:0] val,
                                       output logic ok, output logic bad);
        int unsigned o;
        logic [31:0] s;
        o   = addr % 4;
        s   = raw >> (8 * o);
        ok  = 1'b1;
        bad = 1'b0;
        val = '0;
        case (f3)
            3'd0: begin val = s & 32'hFF;   if (val >= 128)   val = val - 256;   end
            3'd4: val = s & 32'hFF;
            3'd1: begin bad = (o % 2) != 0; val = s & 32'hFFFF; if (val >= 32768) val = val - 65536; end
            3'd5: begin bad = (o % 2) != 0; val = s & 32'hFFFF; end
            3'd2: begin bad = (o != 0); val = s; end
            default: ok = 1'b0;
        endcase
        if (bad || !ok) val = '0;
    endfunction

    // Expected outputs from the modelled stage contents.
    function automatic void model_out(output logic we, output logic [31:0] data,
                                      output logic mis, output logic ret);
        logic writes, is_load, ok, bad, live;
        logic [31:0] lv;
        writes = 1'b0; is_load = 1'b0; ok = 1'b1; bad = 1'b0; data = '0;
        live = m_valid && m_fresh;
        case (m_inst[6:0])
            LOAD: begin
                is_load = 1'b1;
                model_load(m_inst[14:12], m_alu, m_rdata, lv, ok, bad);
                data = lv; writes = ok && !bad;
            end
            ALUI, ALU:  begin data = m_alu;         writes = 1'b1; end
            AUIPC:      begin data = m_pc + m_imm;  writes = 1'b1; end
            LUI:        begin data = m_imm;         writes = 1'b1; end
            JAL, JALR:  begin data = m_pc + 4;      writes = 1'b1; end
            default:    data = '0;
        endcase
        if (!m_valid) data = '0;
        mis = live && is_load && bad;
        we  = live && writes && (m_inst[11:7] != 0);
        ret = live && !mis;
    endfunction

    task automatic compare_all();
        logic we, mis, ret;
        logic [31:0] data;
        model_out(we, data, mis, ret);
        check("wb_we",     64'(wb_we),     64'(we));
        check("wb_rd",     64'(wb_rd),     64'(m_inst[11:7]));
        check("wb_data",   64'(wb_data),   64'(data));
        check("misalign",  64'(misalign),  64'(mis));
        check("fwd_valid", 64'(fwd_valid), 64'(we));
        check("fwd_rd",    64'(fwd_rd),    64'(m_inst[11:7]));
        check("fwd_data",  64'(fwd_data),  64'(data));
        check("retired",   64'(retired),   64'(m_ret));
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_fresh = 1'b0; m_inst = '0; m_pc = '0;
        m_alu = '0; m_rdata = '0; m_imm = '0; m_ret = 0;
    endtask

    // One clock: drive at negedge, advance model at posedge, compare shortly after.
    task automatic step(input logic iv, input logic st, input logic jp, input logic [31:0] inst,
                        input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] rdata, input logic [31:0] imm);
        logic we, mis, ret;
        logic [31:0] data;
        @(negedge clk);
        in_valid = iv; stop = st; jump = jp; inst_M = inst;
        pc_M = pc; alu_res_M = alu; mem_rdata_M = rdata; imm_M = imm;
        @(posedge clk);
        model_out(we, data, mis, ret);
        if (ret) m_ret = (m_ret + 1) % (1 << RET_W);
        if (jp) begin
            m_valid = 1'b0; m_fresh = 1'b0;
        end else if (st) begin
            m_fresh = 1'b0;
        end else if (iv) begin
            m_valid = 1'b1; m_fresh = 1'b1; m_inst = inst;
            m_pc = pc; m_alu = alu; m_rdata = rdata; m_imm = imm;
        end else begin
            m_valid = 1'b0;
        end
        #1 compare_all();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
    endtask

    // Pulse reset low between edges and check that outputs clear without a clock.
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_we",   64'(wb_we),     64'd0);
        check("rst_rd",   64'(wb_rd),     64'd0);
        check("rst_data", 64'(wb_data),   64'd0);
        check("rst_mis",  64'(misalign),  64'd0);
        check("rst_fwd",  64'(fwd_valid), 64'd0);
        check("rst_ret",  64'(retired),   64'd0);
        model_reset();
        @(negedge clk);
        in_valid = 1'b0; stop = 1'b0; jump = 1'b0;
        rst = 1'b1;
    endtask

    logic [6:0] ops [11] = '{LOAD, STORE, BRA, ALUI, ALU, AUIPC, LUI, JAL, JALR, 7'h7F, 7'h00};

    initial begin
        int unsigned r0;
        int          we_cnt;

        // Power-on reset state
        #1;
        check("por_we",   64'(wb_we),   64'd0);
        check("por_data", 64'(wb_data), 64'd0);
        check("por_ret",  64'(retired), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // ADDI rd=5 -> writes 0x1234, retires on the following edge
        step(1'b1, 1'b0, 1'b0, mk(ALUI, 3'd0, 5'd5), 32'h100, 32'h0000_1234, '0, 32'h1234);
        check("addi_we",   64'(wb_we),   64'd1);
        check("addi_rd",   64'(wb_rd),   64'd5);
        check("addi_data", 64'(wb_data), 64'h1234);
        idle();
        check("addi_ret",  64'(retired), 64'd1);

        // LB / LBU from byte 3 of 0x80FF_FF00
        step(1'b1, 1'b0, 1'b0, mk(LOAD, 3'b000, 5'd6), 32'h104, 32'h0000_1003, 32'h80FF_FF00, '0);
        check("lb_data",  64'(wb_data), 64'hFFFF_FF80);
        step(1'b1, 1'b0, 1'b0, mk(LOAD, 3'b100, 5'd7), 32'h108, 32'h0000_1003, 32'h80FF_FF00, '0);
        check("lbu_data", 64'(wb_data), 64'h0000_0080);
        idle();

        // Misaligned LH: flagged, no write, no retirement
        r0 = 32'(retired);
        step(1'b1, 1'b0, 1'b0, mk(LOAD, 3'b001, 5'd8), 32'h10C, 32'h0000_1001, 32'h1234_5678, '0);
        check("lh_mis", 64'(misalign), 64'd1);
        check("lh_we",  64'(wb_we),    64'd0);
        idle();
        check("lh_ret", 64'(retired),  64'(r0));

        // JAL held by a 3-cycle stall writes exactly once
        r0 = 32'(retired);
        step(1'b1, 1'b0, 1'b0, mk(JAL, 3'd0, 5'd1), 32'h2000, '0, '0, 32'h40);
        check("jal_data", 64'(wb_data), 64'h2004);
        we_cnt = int'(wb_we);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, mk(ALU, 3'd0, 5'd9), 32'h2004, 32'hDEAD, '0, '0);
            we_cnt += int'(wb_we);
        end
        check("jal_we_cnt", 64'(we_cnt), 64'd1);
        check("jal_ret", 64'(retired), 64'((r0 + 1) % 16));

        // Flush wins over a simultaneous valid ALU op
        r0 = 32'(retired);
        step(1'b1, 1'b0, 1'b1, mk(ALU, 3'd0, 5'd10), 32'h3000, 32'h55, '0, '0);
        check("flush_we", 64'(wb_we), 64'd0);
        idle();
        check("flush_ret", 64'(retired), 64'(r0));

        // Reset mid-stall, then 17 back-to-back ADDIs wrap the 4-bit counter to 1
        step(1'b1, 1'b0, 1'b0, mk(ALUI, 3'd0, 5'd11), 32'h3100, 32'h77, '0, '0);
        step(1'b1, 1'b1, 1'b0, mk(ALUI, 3'd0, 5'd11), 32'h3100, 32'h77, '0, '0);
        async_reset();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 1'b0, 1'b0, mk(ALUI, 3'd0, 5'(i + 1)), 32'h4000 + 32'(4 * i), 32'(i), '0, '0);
        end
        idle();
        check("wrap_ret", 64'(retired), 64'd1);

        // Randomised traffic, with an asynchronous reset partway through
        for (int i = 0; i < 600; i++) begin
            logic [6:0]  op;
            logic [4:0]  rd;
            if (i == 300) async_reset();
            op = ops[$urandom_range(0, 10)];
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                 {17'($urandom), 3'($urandom), rd, op},
                 $urandom, $urandom, $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Parametrised, registered write-back stage for the RV32I/RV64I pipeline, sitting between the MEM/WB boundary and the register file. It captures one instruction per cycle under stall and flush control. It aligns and sign/zero-extends load data, selects the destination value by opcode, and drives the register-file write port plus a same-cycle forwarding copy. It also flags misaligned loads and keeps a retired-instruction counter.

## Interface
- `XLEN`, 32, datapath width; legal values are 32 or 64.
- `RADDR_W`, 5, register-address width.
- `RET_W`, 32, width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  MEM stage presents an instruction.
- `stop`  in  1  stall; hold the stage contents.
- `jump`  in  1  flush; discard the stage contents.
- `inst_M`  in  32  instruction word; opcode is [6:0], funct3 is [14:12], rd is [11:7].
- `pc_M`  in  XLEN  PC of the instruction.
- `alu_res_M`  in  XLEN  ALU result; also the effective address for loads.
- `mem_rdata_M`  in  XLEN  raw, naturally aligned memory read word.
- `imm_M`  in  XLEN  decoded immediate.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  RADDR_W  destination register.
- `wb_data`  out  XLEN  write data.
- `fwd_valid`, `fwd_rd`, `fwd_data`  out  1/RADDR_W/XLEN  forwarding copy of the three write-back signals.
- `misalign`  out  1  a misaligned load reached write-back this cycle.
- `retired`  out  RET_W  count of retired instructions.

## Operation
- Stage register contents: valid, fresh, opcode, funct3, rd, pc, alu_res, mem_rdata, imm.
- Capture: on an edge with `in_valid & !stop & !jump`, load the stage register and set fresh=1.
- No capture: on an edge with `!in_valid & !stop & !jump`, clear valid.
- Stall (`stop`):
  - Contents are held.
  - fresh clears after the first stalled edge, so `wb_we` pulses once per instruction.
- Flush (`jump`): clears valid and fresh at the next edge. `jump` wins over `stop` and over `in_valid`.
- Write data, selected by opcode:
  - LOAD: the aligned load value (below).
  - ALUI, ALU: alu_res.
  - AUIPC: pc+imm, modulo 2^XLEN.
  - LUI: imm.
  - JAL, JALR: pc+4.
  - Any other opcode: 0.
- Load alignment uses byte offset o = alu_res[log2(XLEN/8)-1:0]:
  - LB/LBU: byte o, sign- or zero-extended to XLEN.
  - LH/LHU: halfword at o; misaligned if o[0]=1.
  - LW: word at o, sign-extended when XLEN=64; misaligned if o[1:0]≠0.
  - funct3 011 (LD) is legal only when XLEN=64, and is misaligned if o≠0. When XLEN=32 it is treated as an unsupported load: data 0, no write.
- `wb_we` = valid & fresh & (opcode ∉ {STORE, BRA, unknown}) & (rd≠0) & !misalign.
- `misalign` = valid & fresh & LOAD & misaligned. On a misaligned load no register write occurs and the instruction does not retire.
- Retirement: `retired` increments by 1 for each instruction with valid & fresh & !misalign. This includes stores, branches and rd=0 writes. The counter wraps from 2^RET_W-1 to 0.
- The fwd_* outputs equal wb_we, wb_rd and wb_data in the same cycle.

## Timing
- Latency: an instruction captured at edge N drives `wb_*` during cycle N+1 (between edges N and N+1+).
- `wb_data`, `wb_we` and `misalign` are combinational from the stage register, with no input-to-output paths.
- Throughput: one instruction per cycle with no bubbles.
- `retired` is registered: it reflects an instruction one edge after that instruction's write-back cycle.
- Reset while `rst` is low:
  - valid=0, fresh=0, all stage fields 0, `retired`=0.
  - Therefore `wb_we`=0, `wb_rd`=0, `wb_data`=0, `misalign`=0, `fwd_valid`=0.
  - Reset mid-stall discards the held instruction.
- Simultaneous `stop` and `in_valid`: the input is ignored; the MEM stage must hold it.

## Structure
- Shared package `riscv_pkg`: OP_* opcode constants, FCT3_LB/LH/LW/LD/LBU/LHU/LWU constants, and an `wb_sel_t` enum (MEM, ALU, PCIMM, IMM, PC4, ZERO).
- Sub-module `load_align`: purely combinational (XLEN, funct3, offset, raw word) → (data, misaligned). It is instantiated once.
- Top level contains the stage register, stall/flush control, the result mux and the counter.

## Test plan
- ADDI with rd=5 and alu_res=0x0000_1234, in_valid pulse → one cycle later: wb_we=1, wb_rd=5, wb_data=0x1234; retired=1 the following cycle.
- LB at addr 0x...03 with mem_rdata=0x80FF_FF00 → wb_data=0xFFFF_FF80. The same access as LBU → 0x0000_0080.
- LH at addr 0x...01 → misalign=1, wb_we=0, retired unchanged.
- A JAL captured, then `stop` held for 3 cycles → wb_we is high for exactly 1 cycle with wb_data=pc+4, and retired increments once.
- `jump` and `in_valid` asserted together with an ALU op → no write next cycle, and retired is unchanged.
- RET_W=4 with 17 back-to-back ADDIs → retired=1 after wrap. Assert `rst` low mid-stream → all outputs 0 asynchronously.
